multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle RISC-V datapath, sitting directly upstream of the sign-extension stage. It decodes the instruction register fields and sequences each instruction through a Moore state machine. It drives the datapath's mux selects, write enables and ALU operation. Its `immSrc` output feeds the sign extender's `src` select (00 I, 01 S, 10 B, 11 J).

## Interface
Parameters: none.

Reset behaviour (already decided): one clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; forces state to FETCH on the next edge
- `op`  in  7  instr[6:0]
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag
- `pcWrite`  out  1  PC register enable
- `adrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `memWrite`  out  1  data memory write enable
- `irWrite`  out  1  instruction register / oldPC enable
- `resultSrc`  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
- `aluSrcA`  out  2  00 PC, 01 oldPC, 10 rs1 reg
- `aluSrcB`  out  2  00 rs2 reg, 01 immExt, 10 constant 4
- `regWrite`  out  1  register file write enable
- `immSrc`  out  2  to sign extender `src`
- `aluControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `state`  out  4  current state, for debug/verification

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other value → FETCH, with no architectural write.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
- Moore outputs per state. Unlisted signals are 0; ALUOp is internal.
  - FETCH: adrSrc 0, irWrite 1, aluSrcA 00, aluSrcB 10, ALUOp 00, resultSrc 10, pcUpdate 1.
  - DECODE: aluSrcA 01, aluSrcB 01, ALUOp 00 (branch target).
  - MEMADR: aluSrcA 10, aluSrcB 01, ALUOp 00.
  - MEMREAD: resultSrc 00, adrSrc 1.
  - MEMWB: resultSrc 01, regWrite 1.
  - MEMWRITE: resultSrc 00, adrSrc 1, memWrite 1.
  - EXECUTER: aluSrcA 10, aluSrcB 00, ALUOp 10.
  - EXECUTEI: aluSrcA 10, aluSrcB 01, ALUOp 10.
  - ALUWB: resultSrc 00, regWrite 1.
  - BEQ: aluSrcA 10, aluSrcB 00, ALUOp 01, resultSrc 00, branch 1.
  - JAL: aluSrcA 01, aluSrcB 10, ALUOp 00, resultSrc 00, pcUpdate 1.
- `pcWrite = pcUpdate | (branch & zero)`. Only beq is supported; `funct3` is ignored for branches.
- `immSrc` is combinational from `op`, independent of state: lw/I-ALU → 00, sw → 01, beq → 10, jal → 11, R-type and others → 00. U-type is not supported.
- ALU decoder, `aluControl`:
  - ALUOp 00 → 000.
  - ALUOp 01 → 001.
  - ALUOp 10, by `funct3`:
    - 000 → 001 if (`op`[5] & `funct7b5`), else 000.
    - 010 → 101.
    - 110 → 011.
    - 111 → 010.
    - any other → 000.
  - ALUOp 11 is never produced.

## Timing
- Only the state register is sequential. All outputs are combinational from state, `op`, `funct3`, `funct7b5` and `zero`, and are valid within the same cycle.
- Instruction latency in cycles, FETCH to the next FETCH: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
- `reset` high at an edge puts state in FETCH, whatever the current state, including mid-instruction.
- While `reset` is high, `pcWrite`, `irWrite`, `regWrite` and `memWrite` are forced to 0 combinationally. All other outputs follow the current state.
- After reset is released, the first FETCH cycle asserts `irWrite` and `pcWrite`.
- BEQ with `zero` = 1 asserts `pcWrite` in that single cycle. With `zero` = 0 nothing is written.
- `op` must stay stable from DECODE through the end of the instruction. The instruction register guarantees this, since `irWrite` is asserted only in FETCH.

## Test plan
- Reset: hold `reset` 2 cycles from state 6. Required: `state` = 0; `pcWrite`/`irWrite`/`regWrite`/`memWrite` = 0 while reset is high; `irWrite` = 1 in the first cycle after release.
- lw, `op` = 0000011: states 0, 1, 2, 3, 4, 0. `immSrc` = 00. `regWrite` = 1 only in state 4 with `resultSrc` = 01. `adrSrc` = 1 in state 3.
- sw, `op` = 0100011: states 0, 1, 2, 5, 0. `immSrc` = 01. `memWrite` = 1 only in state 5.
- R-type sub, `op` = 0110011, `funct3` = 000, `funct7b5` = 1: `aluControl` = 001 in state 6. With `funct3` = 111, `aluControl` = 010. The sequence ends ALUWB then FETCH.
- beq, `op` = 1100011: `immSrc` = 10. In state 9, `zero` = 1 gives `pcWrite` = 1 and `zero` = 0 gives `pcWrite` = 0. Returns to state 0 after 3 cycles.
- jal, `op` = 1101111: `immSrc` = 11, states 0, 1, 10, 8, 0, `pcWrite` = 1 in state 10. An illegal `op` of 1111111 goes 0, 1, 0 with no write enables asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore sequencer over the instruction fields,
// plus combinational immediate-select and ALU decoders.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       regWrite,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     state_q;
    state_t     state_d;
    logic       pc_update;
    logic       branch;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Undefined opcodes fall back to FETCH straight from DECODE.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: state_d = MEMWB;
            EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        adrSrc        = 1'b0;
        resultSrc     = 2'b00;
        aluSrcA       = 2'b00;
        aluSrcB       = 2'b00;
        alu_op        = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write_raw = 1'b1;
                aluSrcB      = 2'b10;
                resultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            MEMREAD: adrSrc = 1'b1;
            MEMWB: begin
                resultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                adrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                aluSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB: reg_write_raw = 1'b1;
            BEQ: begin
                aluSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural write enables are held off for the whole reset cycle.
    assign pcWrite  = ~reset & (pc_update | (branch & zero));
    assign irWrite  = ~reset & ir_write_raw;
    assign regWrite = ~reset & reg_write_raw;
    assign memWrite = ~reset & mem_write_raw;
    assign state    = state_q;

    always_comb begin
        case (op)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    always_comb begin
        aluControl = 3'b000;
        case (alu_op)
            2'b01: aluControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  aluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  aluControl = 3'b101;
                    3'b110:  aluControl = 3'b011;
                    3'b111:  aluControl = 3'b010;
                    default: aluControl = 3'b000;
                endcase
            end
            default: aluControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: one record per clock cycle,
// plus hand-written reset sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic [1:0] immSrc;
    logic [2:0] aluControl;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .regWrite(regWrite), .immSrc(immSrc),
        .aluControl(aluControl), .state(state)
    );

    // Expected word: {state, pcW, irW, regW, memW, adrSrc, resultSrc, aluSrcA, aluSrcB, immSrc, aluControl}
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    // en = {pcWrite, irWrite, regWrite, memWrite, adrSrc}
    function automatic vec_t mk(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic z, input logic [3:0] st,
                                input logic [4:0] en, input logic [1:0] rs, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [1:0] imm, input logic [2:0] alc);
        vec_t v;
        v.rst = rst;
        v.op  = o;
        v.f3  = f3;
        v.f7  = f7;
        v.z   = z;
        v.exp = {st, en, rs, sa, sb, imm, alc};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset    = v.rst;
        op       = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        zero     = v.z;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [19:0] exp);
        logic [19:0] act;
        act = {state, pcWrite, irWrite, regWrite, memWrite, adrSrc,
               resultSrc, aluSrcA, aluSrcB, immSrc, aluControl};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic runRow(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, v.exp);
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);

        // lw: 0,1,2,3,4
        vecs.push_back(mk(0, LW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0, 4'd4, 5'b00100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
        // sw: 0,1,2,5
        vecs.push_back(mk(0, SW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));
        vecs.push_back(mk(0, SW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000));
        vecs.push_back(mk(0, SW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
        vecs.push_back(mk(0, SW, 3'b010, 0, 0, 4'd5, 5'b00011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
        // R-type sub
        vecs.push_back(mk(0, RT, 3'b000, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        vecs.push_back(mk(0, RT, 3'b000, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, RT, 3'b000, 1, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001));
        vecs.push_back(mk(0, RT, 3'b000, 1, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        // R-type and, then or
        vecs.push_back(mk(0, RT, 3'b111, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        vecs.push_back(mk(0, RT, 3'b111, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, RT, 3'b111, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010));
        vecs.push_back(mk(0, RT, 3'b110, 0, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        // addi with funct7b5 set must still add; slti
        vecs.push_back(mk(0, IT, 3'b000, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        vecs.push_back(mk(0, IT, 3'b000, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, IT, 3'b000, 1, 0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, IT, 3'b000, 1, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        vecs.push_back(mk(0, IT, 3'b010, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        vecs.push_back(mk(0, IT, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, IT, 3'b010, 0, 0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101));
        vecs.push_back(mk(0, IT, 3'b010, 0, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        // beq taken, then not taken
        vecs.push_back(mk(0, BQ, 3'b000, 0, 1, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000));
        vecs.push_back(mk(0, BQ, 3'b000, 0, 1, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000));
        vecs.push_back(mk(0, BQ, 3'b000, 0, 1, 4'd9, 5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
        vecs.push_back(mk(0, BQ, 3'b000, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000));
        vecs.push_back(mk(0, BQ, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000));
        vecs.push_back(mk(0, BQ, 3'b000, 0, 0, 4'd9, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
        // jal: 0,1,10,8
        vecs.push_back(mk(0, JL, 3'b000, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000));
        vecs.push_back(mk(0, JL, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000));
        vecs.push_back(mk(0, JL, 3'b000, 0, 0, 4'd10, 5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000));
        vecs.push_back(mk(0, JL, 3'b000, 0, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000));
        // illegal opcode: 0,1,0 with no writes from DECODE
        vecs.push_back(mk(0, BAD, 3'b000, 1, 1, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        vecs.push_back(mk(0, BAD, 3'b000, 1, 1, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        vecs.push_back(mk(0, RT, 3'b000, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

        foreach (vecs[i]) begin
            runRow($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset held two cycles, entered from EXECUTER (state 6).
        runRow("rst_decode", mk(0, RT, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        runRow("rst_in_exec", mk(1, RT, 3'b000, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000));
        runRow("rst_fetch_held", mk(1, RT, 3'b000, 0, 0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        runRow("rst_release", mk(0, RT, 3'b000, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

        // Reset landing on MEMWB must suppress the register write.
        runRow("lw2_decode", mk(0, LW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        runRow("lw2_memadr", mk(0, LW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
        runRow("lw2_memread", mk(0, LW, 3'b010, 0, 0, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        runRow("lw2_memwb_rst", mk(1, LW, 3'b010, 0, 0, 4'd4, 5'b00000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
        runRow("lw2_after_rst", mk(0, LW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

        // Reset during MEMWRITE suppresses memWrite; adrSrc still follows state.
        runRow("sw2_decode", mk(0, SW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000));
        runRow("sw2_memadr", mk(0, SW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
        runRow("sw2_memwrite_rst", mk(1, SW, 3'b010, 0, 0, 4'd5, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
        runRow("sw2_after_rst", mk(0, SW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
